// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data memory between the fetch
// port (I) and the load/store port (D), one outstanding transaction at a time.
// Flow: IDLE -> ISSUE -> WAIT (watchdog) -> RESP -> IDLE.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, a tie goes
// to the port that was not served last. When it is undefined, D wins ties.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wd,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wd,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Watchdog fires on the WAIT edge where the count would reach TIMEOUT.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  wd_cnt;
    logic        owner_d;    // 1 = D owns the in-flight transaction
    logic        pick_d;     // arbitration result in IDLE
    logic        wait_done;  // leaving WAIT this edge (response or timeout)
    logic [31:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_d;

    // On a tie the port that was not served last wins.
    always_comb pick_d = d_req & (~i_req | ~last_owner_d);

    // Remember who was served, updated as the transaction enters RESP.
    always_ff @(posedge CLK) begin
        if (RST)            last_owner_d <= 1'b0;
        else if (wait_done) last_owner_d <= owner_d;
    end
`else
    // Fixed priority: D wins every tie.
    always_comb pick_d = d_req;
`endif

    // A response on the watchdog edge wins over the timeout.
    always_comb begin
        wait_done = (state == S_WAIT) && (m_rvalid || (wd_cnt == WD_LAST));
        resp_data = m_rvalid ? m_rdata : 32'h0000_0000;
    end

    assign busy = (state != S_IDLE);

    // Sequencer: latch request, issue, wait under watchdog, return response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            wd_cnt   <= '0;
            owner_d  <= 1'b0;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            m_valid  <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wd     <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
        end else begin
            // All strobes are single-cycle pulses.
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            m_valid  <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        // Command registers double as the latched request.
                        owner_d <= pick_d;
                        m_we    <= pick_d & d_we;
                        m_addr  <= pick_d ? d_addr : i_addr;
                        m_wd    <= pick_d ? d_wd : 32'h0000_0000;
                        i_gnt   <= ~pick_d;
                        d_gnt   <= pick_d;
                        m_valid <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_done) begin
                        err <= ~m_rvalid;
                        if (owner_d) begin
                            d_rdata  <= resp_data;
                            d_rvalid <= 1'b1;
                        end else begin
                            i_rdata  <= resp_data;
                            i_rvalid <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;  // S_RESP: rvalid pulses this cycle
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver plays both requesters and
// the memory, predicts each grant and response from the arbitration rules and
// cycle arithmetic, and queues them; the monitor checks whatever the DUT shows.
module tb_mem_port_arbiter;

    localparam int TMO = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_req, d_req, d_we, m_rvalid;
    logic [31:0] i_addr, d_addr, d_wd, m_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_valid, m_we, busy, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wd;

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          cyc;
    } cmd_t;

    typedef struct {
        bit          d;
        bit          err;
        logic [31:0] ih;   // i_rdata expected after this response
        logic [31:0] dh;   // d_rdata expected after this response
        int          cyc;
    } resp_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit exp_busy = 1'b0;
    bit chk_zero = 1'b0;
    bit done = 1'b0;

    // Reference model state
    bit          i_pend = 1'b0, d_pend = 1'b0, last_d = 1'b0;
    logic [31:0] i_hold = '0, d_hold = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One arbitration round from IDLE; raises new requests if asked.
    task automatic txn(input bit ni, input bit nd, input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] dwd, input bit dwe, input int lat, input bit spur,
                       input logic [31:0] rd);
        bit win_d, to;
        int eff, g;
        logic [31:0] data;
        if (ni && !i_pend) begin i_pend = 1'b1; i_req = 1'b1; i_addr = ia; end
        if (nd && !d_pend) begin
            d_pend = 1'b1; d_req = 1'b1; d_we = dwe; d_addr = da; d_wd = dwd;
        end
        if (!i_pend && !d_pend) begin
            @(posedge CLK); #1;
            return;
        end
        win_d = (i_pend && d_pend) ? (RR ? !last_d : 1'b1) : d_pend;
        @(posedge CLK); #1;  // request sampled; ISSUE cycle now
        g = cyc;
        exp_busy = 1'b1;
        cmd_q.push_back('{d: win_d, we: win_d && d_we, addr: win_d ? d_addr : i_addr,
                          wd: d_wd, cyc: g});
        to   = (lat > TMO);
        eff  = to ? TMO : lat;
        data = to ? 32'h0 : rd;
        if (win_d) d_hold = data; else i_hold = data;
        resp_q.push_back('{d: win_d, err: to, ih: i_hold, dh: d_hold, cyc: g + eff + 1});
        last_d = win_d;
        // Winner drops its request and scrambles its bus; the latch must hold.
        if (win_d) begin
            d_pend = 1'b0; d_req = 1'b0; d_addr = $urandom; d_wd = $urandom; d_we = 1'($urandom);
        end else begin
            i_pend = 1'b0; i_req = 1'b0; i_addr = $urandom;
        end
        m_rvalid = spur; m_rdata = $urandom;   // ignored outside WAIT
        @(posedge CLK); #1;
        for (int c = 1; c <= eff; c++) begin
            m_rvalid = (c == lat);
            m_rdata  = (c == lat) ? rd : $urandom;
            @(posedge CLK); #1;
        end
        m_rvalid = spur; m_rdata = $urandom;   // RESP cycle, ignored
        @(posedge CLK); #1;
        exp_busy = 1'b0;
        m_rvalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && (i_pend || d_pend); k++)
            txn(1'b0, 1'b0, '0, '0, '0, 1'b0, 1, 1'b0, $urandom);
    endtask

    task automatic rand_txn();
        txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), $urandom_range(1, TMO + 2), ($urandom_range(0, 3) == 0),
            $urandom);
    endtask

    // Load goes out, reset hits in WAIT, memory answers late.
    task automatic reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wd = $urandom;
        @(posedge CLK); #1;
        exp_busy = 1'b1;
        cmd_q.push_back('{d: 1'b1, we: 1'b0, addr: 32'h300, wd: d_wd, cyc: cyc});
        d_req = 1'b0;
        @(posedge CLK); #1;  // first WAIT cycle
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; chk_zero = 1'b1; exp_busy = 1'b0;
        i_hold = '0; d_hold = '0; last_d = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        chk_zero = 1'b0; m_rvalid = 1'b0;
    endtask

    // Driver
    initial begin
        RST = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_rvalid = 1'b0;
        i_addr = '0; d_addr = '0; d_wd = '0; m_rdata = '0;
        @(posedge CLK); #1;
        chk_zero = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk_zero = 1'b0;
        // Tie twice, D re-raising after its grant
        txn(1'b1, 1'b1, 32'h100, 32'h200, 32'h11, 1'b0, 1, 1'b0, 32'hA0A0_0001);
        txn(1'b0, 1'b1, 32'h0, 32'h204, 32'h22, 1'b0, 3, 1'b1, 32'hA0A0_0002);
        drain();
        // Single fetch, then a store
        txn(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1, 1'b0, 32'h1234_5678);
        txn(1'b0, 1'b1, 32'h0, 32'h80, 32'hCAFE_F00D, 1'b1, 2, 1'b0, 32'h5555_AAAA);
        // Watchdog boundaries: response on the last edge, then true timeouts
        txn(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 1'b0, TMO, 1'b0, 32'h7777_0001);
        txn(1'b1, 1'b0, 32'h48, 32'h0, 32'h0, 1'b0, TMO + 1, 1'b1, 32'h7777_0002);
        txn(1'b0, 1'b1, 32'h0, 32'h88, 32'hBEEF, 1'b1, TMO + 2, 1'b0, 32'h7777_0003);
        for (int n = 0; n < 80; n++) rand_txn();
        drain();
        reset_mid();
        txn(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0, 2, 1'b0, 32'h0BAD_F00D);
        for (int n = 0; n < 20; n++) rand_txn();
        drain();
        repeat (3) @(posedge CLK);
        #1 done = 1'b1;
    end

    // Monitor
    always @(negedge CLK) begin
        if (done) begin
            chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
            chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end else begin
            chk("busy", 32'(busy), 32'(exp_busy));
            if (chk_zero) begin
                chk("outputs_zero", 32'(|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                    m_valid, m_we, m_addr, m_wd, busy, err}), 32'd0);
            end else begin
                if (i_gnt || d_gnt || m_valid) begin
                    if (cmd_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_cmd: got gnt i=%0b d=%0b m_valid=%0b expected none",
                                 i_gnt, d_gnt, m_valid);
                    end else begin
                        cmd_t c;
                        c = cmd_q.pop_front();
                        chk("i_gnt", 32'(i_gnt), 32'(!c.d));
                        chk("d_gnt", 32'(d_gnt), 32'(c.d));
                        chk("m_valid", 32'(m_valid), 32'd1);
                        chk("m_we", 32'(m_we), 32'(c.we));
                        chk("m_addr", m_addr, c.addr);
                        if (c.we) chk("m_wd", m_wd, c.wd);
                        chk("gnt_cycle", 32'(cyc), 32'(c.cyc));
                    end
                end
                if (i_rvalid || d_rvalid || err) begin
                    if (resp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_resp: got rvalid i=%0b d=%0b err=%0b expected none",
                                 i_rvalid, d_rvalid, err);
                    end else begin
                        resp_t r;
                        r = resp_q.pop_front();
                        chk("i_rvalid", 32'(i_rvalid), 32'(!r.d));
                        chk("d_rvalid", 32'(d_rvalid), 32'(r.d));
                        chk("err", 32'(err), 32'(r.err));
                        chk("i_rdata", i_rdata, r.ih);
                        chk("d_rdata", d_rdata, r.dh);
                        chk("resp_cycle", 32'(cyc), 32'(r.cyc));
                    end
                end
            end
        end
    end

endmodule
